// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs: AXI4-Lite slave with three RW control registers and one RO status word
module axi_lite_slave_regs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DATA_WIDTH-1:0]   ctrl0_o,
    output logic [DATA_WIDTH-1:0]   ctrl1_o,
    output logic [DATA_WIDTH-1:0]   ctrl2_o,
    input  logic [DATA_WIDTH-1:0]   status_i
);
    localparam logic [RESP_WIDTH-1:0] OKAY = '0;
    localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(2);
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [RESP_WIDTH-1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] ctrl_q [3];
    logic [DATA_WIDTH-1:0] ctrl_d [3];
    logic aw_hs, w_hs, ar_hs, wr_ok;
    logic [2:0] wdec, rdec;

    // {valid, word index}; valid means in-window and word aligned
    function automatic logic [2:0] decode(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return {(a >= BASE_ADDR) && (off < ADDR_WIDTH'(16)) && (off[1:0] == 2'b00), off[3:2]};
    endfunction

    always_comb begin
        aw_hs = s_axi_awvalid & awready_q;
        w_hs = s_axi_wvalid & wready_q;
        w_state_d = w_state_q;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d = w_done_q | w_hs;
        awaddr_d = aw_hs ? s_axi_awaddr : awaddr_q;
        wdata_d = w_hs ? s_axi_wdata : wdata_q;
        wstrb_d = w_hs ? s_axi_wstrb : wstrb_q;
        bvalid_d = bvalid_q;
        bresp_d = bresp_q;
        ctrl_d = ctrl_q;
        wdec = decode(awaddr_d);
        wr_ok = wdec[2] && (wdec[1:0] != 2'd3);
        if (w_state_q == W_IDLE && aw_done_d && w_done_d) begin
            w_state_d = W_RESP;
            bvalid_d = 1'b1;
            bresp_d = wr_ok ? OKAY : SLVERR;
            for (int r = 0; r < 3; r++)
                for (int b = 0; b < SW; b++)
                    if (wr_ok && wdec[1:0] == 2'(r) && wstrb_d[b])
                        ctrl_d[r][b*8 +: 8] = wdata_d[b*8 +: 8];
        end else if (w_state_q == W_RESP && bvalid_q && s_axi_bready) begin
            w_state_d = W_IDLE;
            bvalid_d = 1'b0;
            aw_done_d = 1'b0;
            w_done_d = 1'b0;
        end
        awready_d = (w_state_d == W_IDLE) && !aw_done_d;
        wready_d = (w_state_d == W_IDLE) && !w_done_d;
    end

    always_comb begin
        ar_hs = s_axi_arvalid & arready_q;
        rdec = decode(s_axi_araddr);
        r_state_d = r_state_q;
        rvalid_d = rvalid_q;
        rresp_d = rresp_q;
        rdata_d = rdata_q;
        if (ar_hs) begin
            r_state_d = R_DATA;
            rvalid_d = 1'b1;
            rresp_d = rdec[2] ? OKAY : SLVERR;
            rdata_d = !rdec[2] ? '0 : (rdec[1:0] == 2'd3) ? status_i : ctrl_q[rdec[1:0]];
        end else if (rvalid_q && s_axi_rready) begin
            r_state_d = R_IDLE;
            rvalid_d = 1'b0;
        end
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_done_q <= 1'b0;
            w_done_q <= 1'b0;
            awready_q <= 1'b0;
            wready_q <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            bresp_q <= '0;
            rresp_q <= '0;
            rdata_q <= '0;
            awaddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ctrl_q <= '{default: '0};
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_done_q <= aw_done_d;
            w_done_q <= w_done_d;
            awready_q <= awready_d;
            wready_q <= wready_d;
            arready_q <= arready_d;
            bvalid_q <= bvalid_d;
            rvalid_q <= rvalid_d;
            bresp_q <= bresp_d;
            rresp_q <= rresp_d;
            rdata_q <= rdata_d;
            awaddr_q <= awaddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready = wready_q;
    assign s_axi_arready = arready_q;
    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp = rresp_q;
    assign s_axi_rdata = rdata_q;
    assign ctrl0_o = ctrl_q[0];
    assign ctrl1_o = ctrl_q[1];
    assign ctrl2_o = ctrl_q[2];
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb_axi_lite_slave_regs: directed AXI-Lite transactions checked against a register-map model
module tb_axi_lite_slave_regs;
    logic s_axi_aclk = 1'b0;
    logic s_axi_areset = 1'b1;
    logic [7:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
    logic s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
    logic [31:0] s_axi_wdata = '0, status_i = '0;
    logic [3:0] s_axi_wstrb = '0;
    logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [2:0] s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata, ctrl0_o, ctrl1_o, ctrl2_o;

    axi_lite_slave_regs dut (
        .s_axi_aclk(s_axi_aclk), .s_axi_areset(s_axi_areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .ctrl0_o(ctrl0_o), .ctrl1_o(ctrl1_o), .ctrl2_o(ctrl2_o), .status_i(status_i)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    int n_cmp = 0, n_bad = 0;
    bit cmp_en = 0;
    logic [31:0] m_ctrl [3];
    logic m_bvalid = 0, m_rvalid = 0;
    logic [2:0] m_bresp = 0, m_rresp = 0;
    logic [31:0] m_rdata = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_ok(input logic [7:0] a);
        return (a % 4 == 0) && (a < 16);
    endfunction

    task automatic model_reset();
        m_ctrl = '{default: 32'h0};
        m_bvalid = 0;
        m_rvalid = 0;
    endtask

    always @(negedge s_axi_aclk) begin
        if (cmp_en) begin
            check("ctrl0", ctrl0_o, m_ctrl[0]);
            check("ctrl1", ctrl1_o, m_ctrl[1]);
            check("ctrl2", ctrl2_o, m_ctrl[2]);
            check("bvalid", 32'(s_axi_bvalid), 32'(m_bvalid));
            if (m_bvalid) check("bresp", 32'(s_axi_bresp), 32'(m_bresp));
            check("rvalid", 32'(s_axi_rvalid), 32'(m_rvalid));
            if (m_rvalid) begin
                check("rdata", s_axi_rdata, m_rdata);
                check("rresp", 32'(s_axi_rresp), 32'(m_rresp));
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_ctrl0"}, ctrl0_o, 0);
        check({tag, "_ctrl1"}, ctrl1_o, 0);
        check({tag, "_ctrl2"}, ctrl2_o, 0);
        check({tag, "_rdy"}, {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 0);
        check({tag, "_valid"}, {30'h0, s_axi_bvalid, s_axi_rvalid}, 0);
        check({tag, "_resp"}, {26'h0, s_axi_bresp, s_axi_rresp}, 0);
        check({tag, "_rdata"}, s_axi_rdata, 0);
    endtask

    task automatic send_aw(input logic [7:0] a, input int lag);
        bit ok = 0;
        if (lag > 0) begin repeat (lag) @(posedge s_axi_aclk); #1; end
        s_axi_awaddr = a;
        s_axi_awvalid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin @(negedge s_axi_aclk); ok = s_axi_awready; end
        check("aw_accept", 32'(ok), 1);
        @(posedge s_axi_aclk); #1;
        s_axi_awvalid = 0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int lag);
        bit ok = 0;
        if (lag > 0) begin repeat (lag) @(posedge s_axi_aclk); #1; end
        s_axi_wdata = d;
        s_axi_wstrb = s;
        s_axi_wvalid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin @(negedge s_axi_aclk); ok = s_axi_wready; end
        check("w_accept", 32'(ok), 1);
        @(posedge s_axi_aclk); #1;
        s_axi_wvalid = 0;
    endtask

    // returns #1 after the edge on which the later of AW/W was accepted
    task automatic write_txn(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_lag, input int w_lag);
        fork
            send_aw(a, aw_lag);
            send_w(d, s, w_lag);
        join
        if (addr_ok(a) && a != 8'h0C) begin
            for (int b = 0; b < 4; b++) if (s[b]) m_ctrl[a / 4][b*8 +: 8] = d[b*8 +: 8];
            m_bresp = 0;
        end else m_bresp = 2;
        m_bvalid = 1;
    endtask

    task automatic b_accept(input int delay, input bit stall_chk);
        for (int i = 0; i < delay; i++) begin
            @(negedge s_axi_aclk);
            if (stall_chk) begin
                check("stall_awready", 32'(s_axi_awready), 0);
                check("stall_wready", 32'(s_axi_wready), 0);
            end
            @(posedge s_axi_aclk); #1;
        end
        s_axi_bready = 1;
        @(posedge s_axi_aclk); #1;
        s_axi_bready = 0;
        m_bvalid = 0;
    endtask

    task automatic read_txn(input logic [7:0] a);
        bit ok = 0;
        logic [31:0] exp_d = 0;
        s_axi_araddr = a;
        s_axi_arvalid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin @(negedge s_axi_aclk); ok = s_axi_arready; end
        check("ar_accept", 32'(ok), 1);
        if (addr_ok(a)) exp_d = (a == 8'h0C) ? status_i : m_ctrl[a / 4];
        @(posedge s_axi_aclk); #1;
        s_axi_arvalid = 0;
        m_rvalid = 1;
        m_rdata = exp_d;
        m_rresp = addr_ok(a) ? 3'd0 : 3'd2;
    endtask

    task automatic r_accept(input int delay, input bit stall_chk);
        for (int i = 0; i < delay; i++) begin
            @(negedge s_axi_aclk);
            if (stall_chk) check("stall_arready", 32'(s_axi_arready), 0);
            @(posedge s_axi_aclk); #1;
        end
        s_axi_rready = 1;
        @(posedge s_axi_aclk); #1;
        s_axi_rready = 0;
        m_rvalid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge s_axi_aclk);
        @(negedge s_axi_aclk);
        check_zero("reset");
        @(posedge s_axi_aclk); #1;
        s_axi_areset = 0;
        @(negedge s_axi_aclk);
        check("rdy_before_first_edge", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 0);
        @(negedge s_axi_aclk);
        check("rdy_after_reset", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
        cmp_en = 1;
        @(posedge s_axi_aclk); #1;

        write_txn(8'h04, 32'hDEADBEEF, 4'hF, 0, 0);
        check("same_cycle_ctrl1", ctrl1_o, 32'hDEADBEEF);
        check("same_cycle_bvalid", 32'(s_axi_bvalid), 1);
        check("same_cycle_bresp", 32'(s_axi_bresp), 0);
        b_accept(0, 0);
        read_txn(8'h04);
        check("read_ctrl1", s_axi_rdata, 32'hDEADBEEF);
        r_accept(1, 0);

        write_txn(8'h00, 32'h11223344, 4'hF, 0, 0);
        b_accept(0, 0);
        write_txn(8'h00, 32'hAABBCCDD, 4'h5, 3, 0);
        check("w_first_ctrl0", ctrl0_o, 32'h11BB33DD);
        check("w_first_bresp", 32'(s_axi_bresp), 0);
        b_accept(2, 0);

        write_txn(8'h0C, 32'h12345678, 4'hF, 1, 0);
        check("wr_status_bresp", 32'(s_axi_bresp), 2);
        b_accept(0, 0);
        write_txn(8'h10, 32'h12345678, 4'hF, 0, 2);
        check("wr_oob_bresp", 32'(s_axi_bresp), 2);
        check("wr_oob_ctrl0", ctrl0_o, 32'h11BB33DD);
        b_accept(0, 0);
        write_txn(8'h05, 32'hFFFFFFFF, 4'hF, 0, 0);
        check("wr_misaligned_bresp", 32'(s_axi_bresp), 2);
        b_accept(0, 0);
        read_txn(8'h10);
        check("rd_oob_rdata", s_axi_rdata, 0);
        check("rd_oob_rresp", 32'(s_axi_rresp), 2);
        r_accept(0, 0);

        write_txn(8'h08, 32'h0F0F0F0F, 4'hF, 0, 0);
        b_accept(0, 0);
        write_txn(8'h08, 32'hFFFFFFFF, 4'h0, 0, 0);
        check("strb0_ctrl2", ctrl2_o, 32'h0F0F0F0F);
        check("strb0_bresp", 32'(s_axi_bresp), 0);
        b_accept(0, 0);

        status_i = 32'h0000CAFE;
        read_txn(8'h0C);
        status_i = 32'h0000BEEF;
        check("status_rdata", s_axi_rdata, 32'h0000CAFE);
        r_accept(5, 1);

        write_txn(8'h08, 32'h11111111, 4'hF, 0, 0);
        s_axi_awaddr = 8'h04;
        s_axi_awvalid = 1;
        b_accept(4, 1);
        check("aw_reopen", 32'(s_axi_awready), 1);
        write_txn(8'h04, 32'h22222222, 4'hF, 0, 0);
        check("second_aw_ctrl1", ctrl1_o, 32'h22222222);
        b_accept(0, 0);

        send_aw(8'h00, 0);
        s_axi_areset = 1;
        @(posedge s_axi_aclk); #1;
        model_reset();
        @(negedge s_axi_aclk);
        check_zero("mid_write_reset");
        @(posedge s_axi_aclk); #1;
        s_axi_areset = 0;
        @(posedge s_axi_aclk);
        @(negedge s_axi_aclk);
        check("rdy_after_mid_reset", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
        @(posedge s_axi_aclk); #1;
        write_txn(8'h04, 32'h5A5A5A5A, 4'hF, 2, 0);
        check("post_reset_ctrl1", ctrl1_o, 32'h5A5A5A5A);
        check("post_reset_ctrl0", ctrl0_o, 0);
        b_accept(0, 0);

        repeat (2) @(posedge s_axi_aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width.
REQ-003 SHALL have parameter RESP_WIDTH, default 3, response width; OKAY=0, SLVERR=2.
REQ-004 SHALL have parameter BASE_ADDR, default 0, block base address, 16-byte aligned.
REQ-005 SHALL use one clock and a synchronous, active-high reset: s_axi_aclk (in, 1, clock, rising edge) and s_axi_areset (in, 1, synchronous active-high reset).
REQ-006 SHALL have the write address ports s_axi_awaddr (in, ADDR_WIDTH), s_axi_awvalid (in, 1) and s_axi_awready (out, 1).
REQ-007 SHALL have the write data ports s_axi_wdata (in, DATA_WIDTH), s_axi_wstrb (in, DATA_WIDTH/8, byte enables), s_axi_wvalid (in, 1) and s_axi_wready (out, 1).
REQ-008 SHALL have the write response ports s_axi_bresp (out, RESP_WIDTH), s_axi_bvalid (out, 1) and s_axi_bready (in, 1).
REQ-009 SHALL have the read address ports s_axi_araddr (in, ADDR_WIDTH), s_axi_arvalid (in, 1) and s_axi_arready (out, 1).
REQ-010 SHALL have the read data ports s_axi_rdata (out, DATA_WIDTH), s_axi_rresp (out, RESP_WIDTH), s_axi_rvalid (out, 1) and s_axi_rready (in, 1).
REQ-011 SHALL have the user ports ctrl0_o, ctrl1_o and ctrl2_o (out, DATA_WIDTH each, register contents) and status_i (in, DATA_WIDTH, read-only status).

Function
REQ-012 SHALL use this register map: BASE+0x0 CTRL0 (RW), +0x4 CTRL1 (RW), +0x8 CTRL2 (RW), +0xC STATUS (RO, returns status_i sampled at the AR handshake edge).
REQ-013 SHALL decode as an error any address outside BASE..BASE+0xC or with addr[1:0]!=0, and any write to STATUS.
REQ-014 SHALL use a write FSM with states W_IDLE and W_RESP, and internal aw_done/w_done flags that latch address and data independently.
REQ-015 SHALL drive s_axi_awready=1 in W_IDLE while !aw_done and s_axi_wready=1 in W_IDLE while !w_done, both registered; AW and W may arrive in either order or in the same cycle.
REQ-016 SHALL, on the edge that completes the second of the AW/W handshakes (or both together): write byte lane i of the addressed CTRL register iff wstrb[i]=1; set bvalid=1 and bresp=OKAY (SLVERR on decode error, with no register change); drop both readies; enter W_RESP.
REQ-017 SHALL, in W_RESP, hold bvalid and bresp stable until bvalid&bready; on that edge clear bvalid, aw_done and w_done, go to W_IDLE, and raise both readies on the same edge.
REQ-018 SHALL treat wstrb=0 as an OKAY write with no register change.
REQ-019 SHALL use a read FSM with states R_IDLE (arready=1) and R_DATA (arready=0).
REQ-020 SHALL, on the arvalid&arready edge, register rdata, rresp=OKAY, rvalid=1 and enter R_DATA; on a decode error, rdata=0 and rresp=SLVERR.
REQ-021 SHALL hold rdata, rresp and rvalid stable in R_DATA until rvalid&rready; on that edge clear rvalid, set arready=1 and go to R_IDLE.
REQ-022 SHALL run the read and write FSMs independently; a read whose AR handshake falls on the same edge as a write commit to the same register returns the pre-write value.
REQ-023 SHALL drive ctrlN_o directly from the register flops, changing on the commit edge.

Reset
REQ-024 SHALL, while s_axi_areset=1 at a clock edge, clear CTRL0-2, all readies, bvalid, rvalid, bresp, rresp, rdata, aw_done and w_done, and set both FSMs to idle.
REQ-025 SHALL abandon any in-flight transaction on reset with no register update; readies reach 1 on the first edge with reset low.

Verification
REQ-026 SHALL verify this scenario: AW 0x04 and W 0xDEADBEEF, strb 0xF in the same cycle -> ctrl1_o=0xDEADBEEF one edge later, bvalid=1, bresp=0.
REQ-027 SHALL verify this scenario: W before AW by 3 cycles, CTRL0=0x11223344, addr 0x00, data 0xAABBCCDD, strb 0x5 -> CTRL0=0x11BB33DD, OKAY.
REQ-028 SHALL verify this scenario: write to 0x0C or 0x10 -> bresp=2, CTRL0-2 unchanged; read 0x10 -> rdata=0, rresp=2.
REQ-029 SHALL verify this scenario: read 0x0C with status_i=0x0000CAFE and rready low for 5 cycles -> rvalid and rdata=0x0000CAFE held for 5 cycles, arready=0 throughout.
REQ-030 SHALL verify this scenario: bready held low for 4 cycles after a write -> bvalid stays 1, awready and wready stay 0, and a second AW is not accepted until the B handshake.
REQ-031 SHALL verify this scenario: reset asserted mid-write, after AW and before W -> no register change, all outputs 0, and the next write completes normally.
